// File: rtl/gpio_controller.sv
// gpio_controller: memory-mapped GPIO with atomic set/clear, edge capture and masked irq; GPIO_DEBOUNCE_EN adds an input debouncer.
// Latency: ack/rdata one cycle after req; pin to IN 3 cycles (debounced: DEBOUNCE_CYCLES+3 .. 2*DEBOUNCE_CYCLES+3).
// Backpressure: none, one access per cycle accepted and acked, ack never stalls.
module gpio_controller #(
   parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
   parameter int          IN_WIDTH        = 10,
   parameter int          OUT_WIDTH       = 10,
   parameter int          DEBOUNCE_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req,
   input  logic [31:0]          addr,
   input  logic                 rw,
   input  logic [1:0]           size,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   output logic                 ack,
   input  logic [IN_WIDTH-1:0]  gpio_in,
   output logic [OUT_WIDTH-1:0] gpio_out,
   output logic                 irq
);
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 2");
   end

   logic                 hit;
   logic                 wr;
   logic [2:0]           sel;
   logic [3:0]           lane_en;
   logic [31:0]          wmask;
   logic [31:0]          wbits;
   logic [31:0]          rd_mux;
   logic [31:0]          out_n;
   logic [31:0]          en_n;
   logic [31:0]          edge_clr;
   logic [IN_WIDTH-1:0]  sync1;
   logic [IN_WIDTH-1:0]  sync2;
   logic [IN_WIDTH-1:0]  in_reg;
   logic [IN_WIDTH-1:0]  in_next;
   logic [IN_WIDTH-1:0]  edge_reg;
   logic [IN_WIDTH-1:0]  irq_en;
   logic [OUT_WIDTH-1:0] out_reg;
   logic                 unused_bits;

   assign hit = req && (addr[31:5] == BASE_ADDR[31:5]);
   assign wr  = hit && rw;
   assign sel = addr[4:2];

   always_comb begin
      lane_en = 4'b1111;
      case (size)
         2'd0:    lane_en = 4'b0001 << addr[1:0];
         2'd1:    lane_en = addr[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
   end

   assign wmask = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};
   assign wbits = wdata & wmask;

   // Unwritten lanes: keep for OUT/IRQ_EN, contribute 0 for SET/CLR/RW1C.
   always_comb begin
      out_n    = 32'(out_reg);
      en_n     = 32'(irq_en);
      edge_clr = '0;
      if (wr) begin
         case (sel)
            3'd1:    out_n    = (32'(out_reg) & ~wmask) | wbits;
            3'd2:    out_n    = 32'(out_reg) | wbits;
            3'd3:    out_n    = 32'(out_reg) & ~wbits;
            3'd4:    edge_clr = wbits;
            3'd5:    en_n     = (32'(irq_en) & ~wmask) | wbits;
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (sel)
         3'd0:    rd_mux = 32'(in_reg);
         3'd1:    rd_mux = 32'(out_reg);
         3'd4:    rd_mux = 32'(edge_reg);
         3'd5:    rd_mux = 32'(irq_en);
         default: rd_mux = '0;
      endcase
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0]    tick_cnt;
   logic                tick;
   logic [IN_WIDTH-1:0] prev_smp;
   logic [IN_WIDTH-1:0] agree;

   assign tick    = (tick_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
   assign agree   = ~(sync2 ^ prev_smp);
   // A bit moves only when two consecutive tick samples agree.
   assign in_next = tick ? ((in_reg & ~agree) | (sync2 & agree)) : in_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
         prev_smp <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
         if (tick) prev_smp <= sync2;
      end
   end
`else
   assign in_next = sync2;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= '0;
         sync2    <= '0;
         in_reg   <= '0;
         edge_reg <= '0;
         irq_en   <= '0;
         out_reg  <= '0;
         irq      <= 1'b0;
         ack      <= 1'b0;
         rdata    <= '0;
      end else begin
         sync1    <= gpio_in;
         sync2    <= sync1;
         in_reg   <= in_next;
         // A fresh edge overrides a same-cycle write-1-to-clear.
         edge_reg <= (edge_reg & ~edge_clr[IN_WIDTH-1:0]) | (in_next ^ in_reg);
         irq_en   <= en_n[IN_WIDTH-1:0];
         out_reg  <= out_n[OUT_WIDTH-1:0];
         irq      <= |(edge_reg & irq_en);
         ack      <= hit;
         rdata    <= (hit && !rw) ? rd_mux : '0;
      end
   end

   assign gpio_out    = out_reg;
   assign unused_bits = ^{out_n, en_n, edge_clr};
endmodule

// File: tb/tb_gpio_controller.sv
// Randomised and directed bench for gpio_controller against a cycle-level behavioural model.
module tb_gpio_controller;
   localparam int IW = 10;
   localparam int OW = 10;
   localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef GPIO_DEBOUNCE_EN
   localparam int DC = 4;
`else
   localparam int DC = 50000;
`endif
   localparam logic [31:0] IN_MASK  = 32'((64'd1 << IW) - 64'd1);
   localparam logic [31:0] OUT_MASK = 32'((64'd1 << OW) - 64'd1);

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic [31:0]   addr;
   logic          rw;
   logic [1:0]    size;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic          ack;
   logic [IW-1:0] gpio_in;
   logic [OW-1:0] gpio_out;
   logic          irq;

   always #5 clk = ~clk;

   gpio_controller #(
      .BASE_ADDR(BASE), .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .addr(addr), .rw(rw), .size(size),
      .wdata(wdata), .rdata(rdata), .ack(ack), .gpio_in(gpio_in),
      .gpio_out(gpio_out), .irq(irq)
   );

   int checks = 0;
   int failures = 0;

   // Behavioural model: registers as plain 32-bit words, pin history as a queue.
   logic [31:0] m_in, m_out, m_edge, m_en, m_prev;
   logic        m_irq;
   int          m_cnt;
   logic [31:0] pin_q[$];
   logic        exp_ack;
   logic [31:0] exp_rdata;

   function automatic bit lane_on(int b, logic [1:0] sz, logic [1:0] a);
      if (sz == 2'd0) return b == int'(a);
      if (sz == 2'd1) return (b / 2) == int'(a[1]);
      return 1'b1;
   endfunction

   // Advance one clock with the currently driven inputs, updating the model alongside.
   task automatic cycle();
      logic [31:0] rv, nin, nout, nedge, nen, smp;
      logic [7:0]  wb;
      logic        hit;
      int          sel;
      hit = req && (addr[31:5] == BASE[31:5]);
      sel = int'(addr[4:2]);
      case (sel)
         0: rv = m_in;
         1: rv = m_out;
         4: rv = m_edge;
         5: rv = m_en;
         default: rv = 32'h0;
      endcase
      nout = m_out; nen = m_en; nedge = m_edge;
      if (hit && rw) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_on(b, size, addr[1:0])) begin
               wb = wdata[8*b +: 8];
               case (sel)
                  1: nout[8*b +: 8] = wb;
                  2: nout[8*b +: 8] = nout[8*b +: 8] | wb;
                  3: nout[8*b +: 8] = nout[8*b +: 8] & ~wb;
                  4: nedge[8*b +: 8] = nedge[8*b +: 8] & ~wb;
                  5: nen[8*b +: 8] = wb;
                  default: ;
               endcase
            end
         end
      end
      nout &= OUT_MASK;
      nen  &= IN_MASK;
      pin_q.push_back(32'(gpio_in));
      smp = (pin_q.size() >= 3) ? pin_q[pin_q.size() - 3] : 32'h0;
      if (pin_q.size() > 3) void'(pin_q.pop_front());
`ifdef GPIO_DEBOUNCE_EN
      nin = m_in;
      if (m_cnt == DC - 1) begin
         for (int i = 0; i < IW; i++) if (smp[i] == m_prev[i]) nin[i] = smp[i];
         m_prev = smp;
      end
      m_cnt = (m_cnt + 1) % DC;
`else
      nin = smp;
`endif
      nedge |= (nin ^ m_in);
      exp_ack   = hit;
      exp_rdata = (hit && !rw) ? rv : 32'h0;
      m_irq  = |(m_edge & m_en);
      m_in = nin; m_out = nout; m_edge = nedge; m_en = nen;
      if (rst) begin
         m_in = 0; m_out = 0; m_edge = 0; m_en = 0; m_irq = 0; m_prev = 0; m_cnt = 0;
         exp_ack = 0; exp_rdata = 0;
         pin_q.delete();
         pin_q.push_back(32'h0);
         pin_q.push_back(32'h0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
      req = 1'b1; rw = w; addr = a; size = s; wdata = d;
      cycle();
      req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] offs [4];
      offs = '{32'h00, 32'h04, 32'h10, 32'h14};
      do_reset();
      checks++;
      if (ack !== 1'b0 || gpio_out !== '0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs ack=%b gpio_out=%h irq=%b required 0/0/0", ack, gpio_out, irq);
      end
      foreach (offs[i]) begin
         access(1'b0, BASE + offs[i], 2'd2, 32'h0);
         checks++;
         if (ack !== 1'b1 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_read off=%h ack=%b rdata=%h required ack=1 rdata=0", offs[i], ack, rdata);
         end
      end
   endtask

   task automatic test_set_clr();
      access(1'b1, BASE + 32'h04, 2'd2, 32'h3FF);
      access(1'b1, BASE + 32'h08, 2'd2, 32'h400);
      access(1'b1, BASE + 32'h0C, 2'd2, 32'h00F);
      checks++;
      if (gpio_out !== 10'h3F0) begin
         failures++;
         $display("FAIL set_clr_out gpio_out=%h required 3f0", gpio_out);
      end
      access(1'b0, BASE + 32'h04, 2'd2, 32'h0);
      checks++;
      if (rdata !== 32'h0000_03F0) begin
         failures++;
         $display("FAIL set_clr_read rdata=%h required 000003f0", rdata);
      end
   endtask

   task automatic test_byte_lane();
      access(1'b1, BASE + 32'h04, 2'd2, 32'h0F0);
      access(1'b1, BASE + 32'h05, 2'd0, 32'h0000_0200);
      checks++;
      if (gpio_out !== 10'h2F0) begin
         failures++;
         $display("FAIL byte_lane_out gpio_out=%h required 2f0", gpio_out);
      end
      access(1'b0, BASE + 32'h08, 2'd2, 32'h0);
      checks++;
      if (ack !== 1'b1 || rdata !== 32'h0) begin
         failures++;
         $display("FAIL read_set_reg ack=%b rdata=%h required ack=1 rdata=0", ack, rdata);
      end
      access(1'b0, BASE + 32'h1C, 2'd2, 32'h0);
      checks++;
      if (ack !== 1'b1 || rdata !== 32'h0) begin
         failures++;
         $display("FAIL read_reserved ack=%b rdata=%h required ack=1 rdata=0", ack, rdata);
      end
      access(1'b1, BASE + 32'h06, 2'd1, 32'h0001_0000);
      checks++;
      if (gpio_out !== 10'h2F0) begin
         failures++;
         $display("FAIL half_upper_out gpio_out=%h required 2f0", gpio_out);
      end
   endtask

   task automatic test_back_to_back();
      access(1'b1, BASE + 32'h04, 2'd2, 32'h155);
      access(1'b0, BASE + 32'h04, 2'd2, 32'h0);
      checks++;
      if (ack !== 1'b1 || rdata !== 32'h155) begin
         failures++;
         $display("FAIL b2b_read_after_write ack=%b rdata=%h required ack=1 rdata=155", ack, rdata);
      end
      access(1'b0, 32'h1000_0004, 2'd2, 32'h0);
      checks++;
      if (ack !== 1'b0 || rdata !== 32'h0) begin
         failures++;
         $display("FAIL out_of_window ack=%b rdata=%h required ack=0 rdata=0", ack, rdata);
      end
   endtask

`ifndef GPIO_DEBOUNCE_EN
   task automatic test_edge_irq();
      access(1'b1, BASE + 32'h14, 2'd2, 32'h1);
      gpio_in[0] = 1'b1;
      cycle(); cycle(); cycle();
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_early irq=%b required 0", irq);
      end
      access(1'b0, BASE + 32'h10, 2'd2, 32'h0);
      checks++;
      if (rdata !== 32'h1 || irq !== 1'b1) begin
         failures++;
         $display("FAIL edge_irq_set edge=%h irq=%b required edge=1 irq=1", rdata, irq);
      end
      access(1'b0, BASE + 32'h00, 2'd2, 32'h0);
      checks++;
      if (rdata !== 32'h1) begin
         failures++;
         $display("FAIL in_bit0 rdata=%h required 1", rdata);
      end
      access(1'b1, BASE + 32'h10, 2'd2, 32'h1);
      cycle();
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_cleared irq=%b required 0", irq);
      end
      access(1'b0, BASE + 32'h10, 2'd2, 32'h0);
      checks++;
      if (rdata !== 32'h0) begin
         failures++;
         $display("FAIL edge_cleared rdata=%h required 0", rdata);
      end
   endtask

   task automatic test_rw1c_collision();
      gpio_in[0] = 1'b0;
      cycle(); cycle();
      access(1'b1, BASE + 32'h10, 2'd2, 32'h1);
      access(1'b0, BASE + 32'h10, 2'd2, 32'h0);
      checks++;
      if (rdata !== 32'h1) begin
         failures++;
         $display("FAIL rw1c_collision edge=%h required 1", rdata);
      end
   endtask
`endif

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         req   = ($urandom_range(0, 3) != 0);
         addr  = ($urandom_range(0, 9) == 0) ? $urandom : {BASE[31:5], 5'($urandom)};
         rw    = 1'($urandom);
         size  = 2'($urandom);
         wdata = $urandom;
         if ($urandom_range(0, 5) == 0) gpio_in[$urandom_range(0, IW - 1)] ^= 1'b1;
         cycle();
         checks++;
         if (ack !== exp_ack || rdata !== exp_rdata) begin
            failures++;
            $display("FAIL rand_bus n=%0d ack=%b rdata=%h required ack=%b rdata=%h", n, ack, rdata, exp_ack, exp_rdata);
         end
         checks++;
         if (gpio_out !== m_out[OW-1:0] || irq !== m_irq) begin
            failures++;
            $display("FAIL rand_pins n=%0d gpio_out=%h irq=%b required gpio_out=%h irq=%b", n, gpio_out, irq, m_out[OW-1:0], m_irq);
         end
      end
      req = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      access(1'b1, BASE + 32'h04, 2'd2, 32'h3FF);
      req = 1'b1; rw = 1'b0; addr = BASE + 32'h04; rst = 1'b1;
      cycle();
      rst = 1'b0; req = 1'b0;
      checks++;
      if (ack !== 1'b0 || rdata !== 32'h0 || gpio_out !== '0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_access ack=%b rdata=%h gpio_out=%h irq=%b required all 0", ack, rdata, gpio_out, irq);
      end
   endtask

`ifdef GPIO_DEBOUNCE_EN
   task automatic test_debounce();
      bit found;
      gpio_in = '0;
      do_reset();
      gpio_in[3] = 1'b1;
      cycle();
      gpio_in[3] = 1'b0;
      repeat (12) cycle();
      access(1'b0, BASE + 32'h00, 2'd2, 32'h0);
      checks++;
      if (rdata !== 32'h0) begin
         failures++;
         $display("FAIL glitch_in rdata=%h required 0", rdata);
      end
      access(1'b0, BASE + 32'h10, 2'd2, 32'h0);
      checks++;
      if (rdata !== 32'h0) begin
         failures++;
         $display("FAIL glitch_edge rdata=%h required 0", rdata);
      end
      gpio_in[3] = 1'b1;
      found = 1'b0;
      for (int j = 0; j < 12 && !found; j++) begin
         access(1'b0, BASE + 32'h00, 2'd2, 32'h0);
         if (rdata[3] === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL debounce_latency in3=%b required 1 within 11 cycles", rdata[3]);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; req = 1'b0; addr = '0; rw = 1'b0; size = 2'd2; wdata = '0; gpio_in = '0;
      m_in = 0; m_out = 0; m_edge = 0; m_en = 0; m_prev = 0; m_irq = 0; m_cnt = 0;
      exp_ack = 0; exp_rdata = 0;
      test_reset();
      test_set_clr();
      test_byte_lane();
      test_back_to_back();
`ifndef GPIO_DEBOUNCE_EN
      test_edge_irq();
      test_rw1c_collision();
`endif
      test_random();
      test_reset_mid_access();
`ifdef GPIO_DEBOUNCE_EN
      test_debounce();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
